// File: rtl/cache_mem_responder_pkg.sv
// rtl/cache_mem_responder_pkg.sv - shared types and defaults for the cache memory responder
//
// Purpose: word and RAM-handshake types, responder FSM states and default
// watchdog/block parameters used by the responder and its bench.
// Ports: none (package).

package cache_mem_responder_pkg;

  typedef logic [31:0] word_t;

  // RAM handshake reported by the memory model/controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Responder arbitration states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2,
    ERR  = 2'd3
  } resp_state_t;

  localparam int RESP_TIMEOUT_DEFAULT        = 255;
  localparam int RESP_BLOCK_WORD_BIT_DEFAULT = 2;
  localparam int RESP_CNT_W                  = 8;

endpackage

// File: rtl/cache_mem_responder_flex_counter.sv
// rtl/cache_mem_responder_flex_counter.sv - clearable up-counter for the RAM watchdog
//
// Purpose: counts cycles while count_enable_i is high, returns to zero on
// clear_i (clear wins over enable) or reset.
// Ports:
//   CLK            in  clock, rising edge
//   nRST           in  synchronous active-low reset
//   clear_i        in  force count to zero
//   count_enable_i in  increment this cycle
//   count_o        out current count

module cache_mem_responder_flex_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear_i,
  input  logic         count_enable_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - arbitrates icache/dcache requests onto one RAM port
//
// Purpose: grants the single RAM port to the dcache (priority) or icache,
// holds a dcache grant across a two-word block, forwards RAM data and
// handshake as iwait/dwait, and latches memerr on RAM error or stall.
// Ports:
//   CLK, nRST                 clock (rising) and synchronous active-low reset
//   iREN, iaddr               icache read request and word address
//   iwait, iload              icache stall and instruction data
//   dREN, dWEN, daddr, dstore dcache read/write request, address, write data
//   dwait, dload              dcache stall and read data
//   ramREN, ramWEN            RAM read/write enables
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramstate         RAM read data and handshake
//   memerr                    sticky error, cleared only by reset

module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int RAM_TIMEOUT    = RESP_TIMEOUT_DEFAULT,
  parameter int BLOCK_WORD_BIT = RESP_BLOCK_WORD_BIT_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      memerr
);

  // The counter holds the number of earlier consecutive stalled grant
  // cycles, so the RAM_TIMEOUT-th stall is the one seen with this value.
  localparam logic [RESP_CNT_W-1:0] TIMEOUT_LAST = RESP_CNT_W'(RAM_TIMEOUT - 1);

  resp_state_t            state_q;
  resp_state_t            state_d;
  logic [RESP_CNT_W-1:0]  stall_cnt;
  logic                   granted;
  logic                   access;
  logic                   stall;
  logic                   timeout_hit;
  logic                   ram_fault;

  assign granted     = (state_q == DGNT) || (state_q == IGNT);
  assign access      = (ramstate == ACCESS);
  assign stall       = granted && !access;
  assign timeout_hit = stall && (stall_cnt == TIMEOUT_LAST);
  assign ram_fault   = granted && ((ramstate == ERROR) || timeout_hit);

  cache_mem_responder_flex_counter #(
    .W (RESP_CNT_W)
  ) u_watchdog (
    .CLK            (CLK),
    .nRST           (nRST),
    .clear_i        (!granted || access),
    .count_enable_i (stall),
    .count_o        (stall_cnt)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    memerr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d = DGNT;
        end else if (iREN) begin
          state_d = IGNT;
        end
      end

      DGNT: begin
        ramWEN   = dWEN;
        ramREN   = dREN && !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = !access;
        // A withdrawn request releases the lock even before the second word,
        // which is how single-word writes get out of DGNT.
        if (ram_fault) begin
          state_d = ERR;
        end else if (!(dREN || dWEN)) begin
          state_d = IDLE;
        end else if (access && daddr[BLOCK_WORD_BIT]) begin
          state_d = IDLE;
        end
      end

      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = !access;
        if (ram_fault) begin
          state_d = ERR;
        end else if (access || !iREN) begin
          state_d = IDLE;
        end
      end

      ERR: begin
        memerr = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed self-checking bench for cache_mem_responder

module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      memerr;

  int n_checks;
  int n_pass;

  cache_mem_responder #(
    .RAM_TIMEOUT    (4),
    .BLOCK_WORD_BIT (2)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .memerr   (memerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic at_neg();
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;
    tick();
    tick();
    nRST = 1'b1;

    // Reset state
    at_neg();
    check("rst_ramREN", 32'(ramREN), 32'h0);
    check("rst_ramWEN", 32'(ramWEN), 32'h0);
    check("rst_iwait", 32'(iwait), 32'h1);
    check("rst_dwait", 32'(dwait), 32'h1);
    check("rst_memerr", 32'(memerr), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iload", iload, 32'h0);
    check("rst_dload", dload, 32'h0);

    // Instruction fetch: BUSY, BUSY, ACCESS
    tick();
    iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; ramload = 32'h8C010004;
    at_neg();
    check("if_arb_ramREN", 32'(ramREN), 32'h0);
    tick();
    at_neg();
    check("if_b1_ramREN", 32'(ramREN), 32'h1);
    check("if_b1_ramaddr", ramaddr, 32'h40);
    check("if_b1_iwait", 32'(iwait), 32'h1);
    check("if_b1_dwait", 32'(dwait), 32'h1);
    tick();
    at_neg();
    check("if_b2_iwait", 32'(iwait), 32'h1);
    tick();
    ramstate = ACCESS;
    at_neg();
    check("if_acc_iwait", 32'(iwait), 32'h0);
    check("if_acc_iload", iload, 32'h8C010004);
    tick();
    iREN = 1'b0; ramstate = FREE;
    at_neg();
    check("if_done_ramREN", 32'(ramREN), 32'h0);
    check("if_done_iwait", 32'(iwait), 32'h1);

    // Simultaneous dREN/iREN: dcache block first, then icache
    tick();
    dREN = 1'b1; daddr = 32'h100; iREN = 1'b1; iaddr = 32'h80; ramload = 32'h11111111;
    at_neg();
    check("pr_arb_ramREN", 32'(ramREN), 32'h0);
    tick();
    ramstate = ACCESS;
    at_neg();
    check("pr_w0_ramaddr", ramaddr, 32'h100);
    check("pr_w0_dwait", 32'(dwait), 32'h0);
    check("pr_w0_dload", dload, 32'h11111111);
    check("pr_w0_iwait", 32'(iwait), 32'h1);
    tick();
    daddr = 32'h104; ramload = 32'h22222222;
    at_neg();
    check("pr_w1_ramaddr", ramaddr, 32'h104);
    check("pr_w1_dwait", 32'(dwait), 32'h0);
    check("pr_w1_dload", dload, 32'h22222222);
    check("pr_w1_iwait", 32'(iwait), 32'h1);
    tick();
    dREN = 1'b0; ramstate = FREE;
    at_neg();
    check("pr_idle_ramREN", 32'(ramREN), 32'h0);
    check("pr_idle_iwait", 32'(iwait), 32'h1);
    tick();
    ramstate = ACCESS; ramload = 32'h33333333;
    at_neg();
    check("pr_if_ramaddr", ramaddr, 32'h80);
    check("pr_if_iwait", 32'(iwait), 32'h0);
    check("pr_if_iload", iload, 32'h33333333);
    check("pr_if_dwait", 32'(dwait), 32'h1);
    tick();
    iREN = 1'b0; ramstate = FREE;

    // Block write with iREN held: no icache grant between words
    tick();
    dWEN = 1'b1; daddr = 32'h200; dstore = 32'hAAAA; iREN = 1'b1; iaddr = 32'h80; ramstate = BUSY;
    at_neg();
    check("bw_arb_ramWEN", 32'(ramWEN), 32'h0);
    tick();
    at_neg();
    check("bw_w0_ramWEN", 32'(ramWEN), 32'h1);
    check("bw_w0_ramREN", 32'(ramREN), 32'h0);
    check("bw_w0_ramaddr", ramaddr, 32'h200);
    check("bw_w0_ramstore", ramstore, 32'hAAAA);
    check("bw_w0_busy_dwait", 32'(dwait), 32'h1);
    tick();
    ramstate = ACCESS;
    at_neg();
    check("bw_w0_acc_dwait", 32'(dwait), 32'h0);
    tick();
    daddr = 32'h204; dstore = 32'hBBBB; dREN = 1'b1; ramstate = BUSY;
    at_neg();
    check("bw_w1_ramWEN", 32'(ramWEN), 32'h1);
    check("bw_w1_wr_wins", 32'(ramREN), 32'h0);
    check("bw_w1_ramaddr", ramaddr, 32'h204);
    check("bw_w1_ramstore", ramstore, 32'hBBBB);
    check("bw_w1_iwait", 32'(iwait), 32'h1);
    tick();
    dREN = 1'b0; ramstate = ACCESS;
    at_neg();
    check("bw_w1_acc_dwait", 32'(dwait), 32'h0);
    tick();
    dWEN = 1'b0; iREN = 1'b0; ramstate = FREE;
    at_neg();
    check("bw_idle_ramWEN", 32'(ramWEN), 32'h0);
    check("bw_idle_ramREN", 32'(ramREN), 32'h0);

    // Single-word write then withdrawal
    tick();
    dWEN = 1'b1; daddr = 32'h3100; dstore = 32'hCAFE;
    tick();
    ramstate = ACCESS;
    at_neg();
    check("sw_ramWEN", 32'(ramWEN), 32'h1);
    check("sw_ramaddr", ramaddr, 32'h3100);
    check("sw_dwait", 32'(dwait), 32'h0);
    tick();
    dWEN = 1'b0; ramstate = FREE;
    at_neg();
    check("sw_drop_ramWEN", 32'(ramWEN), 32'h0);
    check("sw_drop_dwait", 32'(dwait), 32'h1);
    tick();
    iREN = 1'b1; iaddr = 32'h44;
    at_neg();
    check("sw_arb_ramREN", 32'(ramREN), 32'h0);
    tick();
    ramstate = ACCESS; ramload = 32'h55;
    at_neg();
    check("sw_if_ramaddr", ramaddr, 32'h44);
    check("sw_if_iwait", 32'(iwait), 32'h0);
    check("sw_if_iload", iload, 32'h55);
    tick();
    iREN = 1'b0; ramstate = FREE;

    // Watchdog: RAM stuck BUSY for RAM_TIMEOUT=4 granted cycles
    tick();
    dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
    for (int c = 1; c <= 4; c++) begin
      tick();
      at_neg();
      check($sformatf("wd_c%0d_memerr", c), 32'(memerr), 32'h0);
      check($sformatf("wd_c%0d_ramREN", c), 32'(ramREN), 32'h1);
    end
    tick();
    iREN = 1'b1;
    at_neg();
    check("wd_err_memerr", 32'(memerr), 32'h1);
    check("wd_err_iwait", 32'(iwait), 32'h1);
    check("wd_err_dwait", 32'(dwait), 32'h1);
    check("wd_err_ramREN", 32'(ramREN), 32'h0);
    tick();
    dREN = 1'b0; iREN = 1'b0; ramstate = ACCESS;
    at_neg();
    check("wd_hold_memerr", 32'(memerr), 32'h1);
    check("wd_hold_iwait", 32'(iwait), 32'h1);
    tick();
    nRST = 1'b0; ramstate = FREE;
    at_neg();
    check("wd_prerst_memerr", 32'(memerr), 32'h1);
    tick();
    nRST = 1'b1;
    at_neg();
    check("wd_rst_memerr", 32'(memerr), 32'h0);

    // Reset pulsed mid-block in DGNT
    tick();
    dREN = 1'b1; daddr = 32'h500;
    tick();
    ramstate = ACCESS;
    at_neg();
    check("mr_w0_dwait", 32'(dwait), 32'h0);
    tick();
    daddr = 32'h504; ramstate = BUSY; nRST = 1'b0;
    at_neg();
    check("mr_w1_ramREN", 32'(ramREN), 32'h1);
    tick();
    nRST = 1'b1;
    at_neg();
    check("mr_post_ramREN", 32'(ramREN), 32'h0);
    check("mr_post_ramWEN", 32'(ramWEN), 32'h0);
    check("mr_post_dwait", 32'(dwait), 32'h1);
    check("mr_post_ramaddr", ramaddr, 32'h0);
    tick();
    dREN = 1'b0; ramstate = FREE;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
